// File: rtl/sect163r2_pt_check.sv
// sect163r2 public-key on-curve check: y*(y+x) == x^2*(x+1) + b over GF(2^163), one serial multiplier.
// SECT_PT_CHECK_FAST_SQR_EN: compute x^2 with a single-cycle combinational squarer instead of MUL2 passes.
module sect163r2_pt_check (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         start,
    input  logic [162:0] x,
    input  logic [162:0] y,
    output logic         busy,
    output logic         done,
    output logic         valid
);
    localparam int M = 163;
    localparam logic [M-1:0] FX = 163'hc9;
    localparam logic [M-1:0] B  = 163'h20a601907b8c953ca1481eb10512f78744a3205fd;
    localparam logic [7:0]   LAST = 8'(M - 1);

    typedef enum logic [2:0] {IDLE, MUL1, MUL2, MUL3, CMP, DONE} state_t;

    state_t       state;
    logic [7:0]   cnt;
    logic [M-1:0] xr, yr, ur, acc, t1, t2;
    logic [M-1:0] opa, opb, shifted, acc_next;

`ifdef SECT_PT_CHECK_FAST_SQR_EN
    // Squaring in GF(2) is bit interleave; fold the high half back down from the top.
    function automatic logic [M-1:0] gf_sqr(input logic [M-1:0] v);
        logic [2*M-1:0] s;
        logic [2*M-1:0] p;
        s = '0;
        p = {{(M-1){1'b0}}, 1'b1, FX};
        for (int i = 0; i < M; i++) s[2*i] = v[i];
        for (int k = 2*M-2; k >= M; k--)
            if (s[k]) s = s ^ (p << (k - M));
        return s[M-1:0];
    endfunction
`endif

    always_comb begin
        opa = '0;
        opb = '0;
        case (state)
            MUL1:    begin opa = yr; opb = ur; end
            MUL2:    begin opa = xr; opb = xr; end
            MUL3:    begin opa = t2; opb = xr ^ {{(M-1){1'b0}}, 1'b1}; end
            default: ;
        endcase
        shifted  = {acc[M-2:0], 1'b0} ^ (acc[M-1] ? FX : '0);
        acc_next = shifted ^ (opb[cnt] ? opa : '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state <= IDLE;
            cnt   <= '0;
            xr    <= '0;
            yr    <= '0;
            ur    <= '0;
            acc   <= '0;
            t1    <= '0;
            t2    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    xr    <= x;
                    yr    <= y;
                    ur    <= x ^ y;
                    acc   <= '0;
                    cnt   <= LAST;
                    valid <= 1'b0;
                    busy  <= 1'b1;
                    state <= MUL1;
                end
                MUL1: begin
                    acc <= acc_next;
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd0) begin
                        t1    <= acc_next;
                        acc   <= '0;
                        cnt   <= LAST;
                        state <= MUL2;
                    end
                end
                MUL2: begin
`ifdef SECT_PT_CHECK_FAST_SQR_EN
                    t2    <= gf_sqr(xr);
                    cnt   <= LAST;
                    state <= MUL3;
`else
                    acc <= acc_next;
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd0) begin
                        t2    <= acc_next;
                        acc   <= '0;
                        cnt   <= LAST;
                        state <= MUL3;
                    end
`endif
                end
                MUL3: begin
                    acc <= acc_next;
                    if (cnt == 8'd0) state <= CMP;
                    else             cnt   <= cnt - 8'd1;
                end
                CMP: begin
                    valid <= (t1 == (acc ^ B));
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sect163r2_pt_check.sv
// Directed bench for sect163r2_pt_check: vector table of candidate points plus abort/overlap sequences.
module tb_sect163r2_pt_check;
    localparam int M = 163;
`ifdef SECT_PT_CHECK_FAST_SQR_EN
    localparam int LAT = 2*M + 2;  // edges after the accepting edge until done is seen
`else
    localparam int LAT = 3*M + 1;
`endif
    localparam logic [M-1:0] FX = 163'hc9;
    localparam logic [M-1:0] BC = 163'h20a601907b8c953ca1481eb10512f78744a3205fd;
    localparam logic [M-1:0] XG = 163'h3f0eba16286a2d57ea0991168d4994637e8343e36;
    localparam logic [M-1:0] YG = 163'h0d51fbc6c71a0094fa2cdd545b11c5c0c797324f1;

    logic clk = 0, rst_n = 0, clr = 0, start = 0;
    logic [M-1:0] x = '0, y = '0;
    logic busy, done, valid;
    int n_cmp = 0, n_err = 0;

    sect163r2_pt_check dut (.clk(clk), .rst_n(rst_n), .clr(clr), .start(start),
                            .x(x), .y(y), .busy(busy), .done(done), .valid(valid));

    always #5 clk = ~clk;

    typedef struct {
        logic [M-1:0] x;
        logic [M-1:0] y;
        logic         exp;
        string        nm;
    } vec_t;
    vec_t tbl[8];

    // Schoolbook product then top-down reduction; used only to derive sqrt(b).
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [2*M-1:0] p, poly;
        p = '0;
        poly = {{(M-1){1'b0}}, 1'b1, FX};
        for (int i = 0; i < M; i++) if (b[i]) p = p ^ ({{M{1'b0}}, a} << i);
        for (int k = 2*M-2; k >= M; k--) if (p[k]) p = p ^ (poly << (k - M));
        return p[M-1:0];
    endfunction

    task automatic check(input string nm, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic start_op(input logic [M-1:0] xi, input logic [M-1:0] yi);
        @(negedge clk);
        x = xi; y = yi; start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    // Returns the edge count (after the accepting edge) at which done is first seen, -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= LAT + 50; n++) begin
            @(posedge clk); #1;
            if (done) begin lat = n; break; end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        start_op(v.x, v.y);
        wait_done(lat);
        check({v.nm, " latency"}, lat, LAT);
        check({v.nm, " valid"}, valid, v.exp);
        @(posedge clk); #1;
        check({v.nm, " done one cycle"}, done, 0);
        check({v.nm, " busy drop"}, busy, 0);
    endtask

    initial begin
        logic [M-1:0] sqb;
        int lat, busy_cnt, done_cnt, done_at;

        sqb = BC;
        for (int i = 0; i < M - 1; i++) sqb = gf_mul(sqb, sqb);  // sqrt(b) = b^(2^(M-1))

        tbl[0] = '{XG, YG,            1'b1, "G"};
        tbl[1] = '{XG, XG ^ YG,       1'b1, "-G"};
        tbl[2] = '{XG, YG ^ 163'd1,   1'b0, "G y^1"};
        tbl[3] = '{'0, '0,            1'b0, "(0,0)"};
        tbl[4] = '{'0, sqb,           1'b1, "(0,sqrt b)"};
        tbl[5] = '{XG, '0,            1'b0, "(XG,0)"};
        tbl[6] = '{'0, 163'd1,        1'b0, "(0,1)"};
        tbl[7] = '{163'd1, '0,        1'b0, "(1,0)"};

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset valid", valid, 0);
        @(negedge clk); rst_n = 1;

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // valid from the last 1-result is cleared on the accepting edge; busy/done profile of (0,0)
        run_vec(tbl[0]);
        start_op('0, '0);
        check("valid cleared on accept", valid, 0);
        check("busy after accept", busy, 1);
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int n = 1; n <= LAT + 3; n++) begin
            @(posedge clk); #1;
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_at = n; end
        end
        check("(0,0) busy cycles", busy_cnt, LAT);
        check("(0,0) done count", done_cnt, 1);
        check("(0,0) done position", done_at, LAT);
        check("(0,0) valid", valid, 0);

        // start pulses while busy with garbage operands must be ignored
        start_op(XG, YG);
        done_cnt = 0; done_at = -1;
        for (int n = 1; n <= LAT + 3; n++) begin
            if (n == 10 || n == 200) begin x = '0; y = 163'd5; start = 1; end
            @(posedge clk); #1;
            start = 0;
            if (done) begin done_cnt++; done_at = n; end
        end
        check("ignored start done count", done_cnt, 1);
        check("ignored start done position", done_at, LAT);
        check("ignored start valid", valid, 1);

        // clr mid-operation aborts; clr+start in the same cycle drops the start
        start_op(XG, YG);
        repeat (248) @(posedge clk);
        @(negedge clk); clr = 1; start = 1;
        @(posedge clk); #1;
        clr = 0; start = 0;
        check("clr busy", busy, 0);
        check("clr valid", valid, 0);
        done_cnt = 0; busy_cnt = 0;
        for (int n = 0; n < LAT + 10; n++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
        check("clr no done", done_cnt, 0);
        check("clr+start dropped", busy_cnt, 0);
        run_vec(tbl[0]);

        // synchronous reset pulse mid-run (MUL2 in the serial build)
        start_op(XG, YG);
        repeat (199) @(posedge clk);
        @(negedge clk); rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst valid", valid, 0);
        done_cnt = 0;
        for (int n = 0; n < LAT + 10; n++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check("rst no done", done_cnt, 0);

        // back-to-back: start during DONE is ignored, next one accepted in the following IDLE cycle
        start_op(XG, YG);
        wait_done(lat);
        check("b2b G latency", lat, LAT);
        check("b2b G valid", valid, 1);
        x = '0; y = '0; start = 1;   // seen on the DONE edge
        @(posedge clk); #1;
        check("start in DONE ignored", busy, 0);
        @(posedge clk); #1;          // IDLE edge accepts it
        start = 0;
        check("b2b second accepted", busy, 1);
        wait_done(lat);
        check("b2b (0,0) latency", lat, LAT);
        check("b2b (0,0) valid", valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
